// File: rtl/vx_commit_writeback.sv
// vx_commit_writeback: collects commit streams, grants one register writeback per cycle
// round-robin and reports the per-cycle retire count.
module vx_commit_writeback #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NR_BITS     = 6,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [NW_BITS-1:0]        alu_wid,
    input  logic [31:0]               alu_PC,
    input  logic [NUM_THREADS-1:0]    alu_tmask,
    input  logic                      alu_wb,
    input  logic [NR_BITS-1:0]        alu_rd,
    input  logic [NUM_THREADS*32-1:0] alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [NW_BITS-1:0]        ld_wid,
    input  logic [31:0]               ld_PC,
    input  logic [NUM_THREADS-1:0]    ld_tmask,
    input  logic                      ld_wb,
    input  logic [NR_BITS-1:0]        ld_rd,
    input  logic [NUM_THREADS*32-1:0] ld_data,
    input  logic                      csr_valid,
    output logic                      csr_ready,
    input  logic [NW_BITS-1:0]        csr_wid,
    input  logic [31:0]               csr_PC,
    input  logic [NUM_THREADS-1:0]    csr_tmask,
    input  logic                      csr_wb,
    input  logic [NR_BITS-1:0]        csr_rd,
    input  logic [NUM_THREADS*32-1:0] csr_data,
    input  logic                      fpu_valid,
    output logic                      fpu_ready,
    input  logic [NW_BITS-1:0]        fpu_wid,
    input  logic [31:0]               fpu_PC,
    input  logic [NUM_THREADS-1:0]    fpu_tmask,
    input  logic                      fpu_wb,
    input  logic [NR_BITS-1:0]        fpu_rd,
    input  logic [NUM_THREADS*32-1:0] fpu_data,
    input  logic                      gpu_valid,
    output logic                      gpu_ready,
    input  logic [NW_BITS-1:0]        gpu_wid,
    input  logic [31:0]               gpu_PC,
    input  logic [NUM_THREADS-1:0]    gpu_tmask,
    input  logic                      gpu_wb,
    input  logic [NR_BITS-1:0]        gpu_rd,
    input  logic [NUM_THREADS*32-1:0] gpu_data,
    input  logic                      st_valid,
    output logic                      st_ready,
    output logic                      wb_valid,
    output logic [NW_BITS-1:0]        wb_wid,
    output logic [31:0]               wb_PC,
    output logic [NUM_THREADS-1:0]    wb_tmask,
    output logic [NR_BITS-1:0]        wb_rd,
    output logic [NUM_THREADS*32-1:0] wb_data,
    output logic                      cmt_valid,
    output logic [2:0]                cmt_size
);
    localparam int NS = 5;
    localparam int DW = NUM_THREADS * 32;

    logic [NS-1:0]          valid, wb, ready;
    logic [NW_BITS-1:0]     wid   [NS];
    logic [31:0]            pc    [NS];
    logic [NUM_THREADS-1:0] tmask [NS];
    logic [NR_BITS-1:0]     rd    [NS];
    logic [DW-1:0]          data  [NS];
    logic [2:0]             rr, g, n;
    logic [3:0]             idx;
    logic                   found;

    assign valid = {gpu_valid, fpu_valid, csr_valid, ld_valid, alu_valid};
    assign wb    = {gpu_wb, fpu_wb, csr_wb, ld_wb, alu_wb};
    assign wid   = '{alu_wid, ld_wid, csr_wid, fpu_wid, gpu_wid};
    assign pc    = '{alu_PC, ld_PC, csr_PC, fpu_PC, gpu_PC};
    assign tmask = '{alu_tmask, ld_tmask, csr_tmask, fpu_tmask, gpu_tmask};
    assign rd    = '{alu_rd, ld_rd, csr_rd, fpu_rd, gpu_rd};
    assign data  = '{alu_data, ld_data, csr_data, fpu_data, gpu_data};

    // First writeback requester at or after rr, wrapping modulo 5.
    always_comb begin
        found = 1'b0;
        g     = 3'd0;
        idx   = 4'd0;
        for (int k = 0; k < NS; k++) begin
            idx = {1'b0, rr} + 4'(k);
            idx = (idx >= 4'd5) ? idx - 4'd5 : idx;
            if (!found && valid[idx[2:0]] && wb[idx[2:0]]) begin
                found = 1'b1;
                g     = idx[2:0];
            end
        end
    end

    always_comb begin
        n = {2'b0, found} + {2'b0, st_valid};
        for (int k = 0; k < NS; k++) n = n + {2'b0, valid[k] & ~wb[k]};
    end

    // Silent commits always pass; writeback commits only on grant.
    for (genvar i = 0; i < NS; i++) begin : g_rdy
        assign ready[i] = reset & (~wb[i] | (found & (g == 3'(i))));
    end

    assign {gpu_ready, fpu_ready, csr_ready, ld_ready, alu_ready} = ready;
    assign st_ready = reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr        <= 3'd0;
            wb_valid  <= 1'b0;
            wb_wid    <= '0;
            wb_PC     <= '0;
            wb_tmask  <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
            cmt_valid <= 1'b0;
            cmt_size  <= 3'd0;
        end else begin
            wb_valid  <= found;
            cmt_valid <= (n != 3'd0);
            cmt_size  <= n;
            if (found) begin
                rr       <= (g == 3'd4) ? 3'd0 : g + 3'd1;
                wb_wid   <= wid[g];
                wb_PC    <= pc[g];
                wb_tmask <= tmask[g];
                wb_rd    <= rd[g];
                wb_data  <= data[g];
            end
        end
    end
endmodule

// File: tb/tb_vx_commit_writeback.sv
// tb_vx_commit_writeback: table-driven vectors with a scoreboard queue for the
// registered writeback/retire outputs, plus reset corner sequences.
module tb_vx_commit_writeback;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]   s_v, s_wb;
    logic         st_v;
    logic [1:0]   s_wid  [5];
    logic [31:0]  s_pc   [5];
    logic [3:0]   s_tm   [5];
    logic [5:0]   s_rd   [5];
    logic [127:0] s_data [5];
    int           seq    [5];
    wire  [4:0]   rdy;
    wire          st_rdy, wb_valid, cmt_valid;
    wire  [1:0]   wb_wid;
    wire  [31:0]  wb_PC;
    wire  [3:0]   wb_tmask;
    wire  [5:0]   wb_rd;
    wire  [127:0] wb_data;
    wire  [2:0]   cmt_size;

    vx_commit_writeback #(.NUM_THREADS(4), .NUM_WARPS(4), .NR_BITS(6), .NW_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(s_v[0]), .alu_ready(rdy[0]), .alu_wid(s_wid[0]), .alu_PC(s_pc[0]),
        .alu_tmask(s_tm[0]), .alu_wb(s_wb[0]), .alu_rd(s_rd[0]), .alu_data(s_data[0]),
        .ld_valid(s_v[1]), .ld_ready(rdy[1]), .ld_wid(s_wid[1]), .ld_PC(s_pc[1]),
        .ld_tmask(s_tm[1]), .ld_wb(s_wb[1]), .ld_rd(s_rd[1]), .ld_data(s_data[1]),
        .csr_valid(s_v[2]), .csr_ready(rdy[2]), .csr_wid(s_wid[2]), .csr_PC(s_pc[2]),
        .csr_tmask(s_tm[2]), .csr_wb(s_wb[2]), .csr_rd(s_rd[2]), .csr_data(s_data[2]),
        .fpu_valid(s_v[3]), .fpu_ready(rdy[3]), .fpu_wid(s_wid[3]), .fpu_PC(s_pc[3]),
        .fpu_tmask(s_tm[3]), .fpu_wb(s_wb[3]), .fpu_rd(s_rd[3]), .fpu_data(s_data[3]),
        .gpu_valid(s_v[4]), .gpu_ready(rdy[4]), .gpu_wid(s_wid[4]), .gpu_PC(s_pc[4]),
        .gpu_tmask(s_tm[4]), .gpu_wb(s_wb[4]), .gpu_rd(s_rd[4]), .gpu_data(s_data[4]),
        .st_valid(st_v), .st_ready(st_rdy),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_PC(wb_PC), .wb_tmask(wb_tmask),
        .wb_rd(wb_rd), .wb_data(wb_data), .cmt_valid(cmt_valid), .cmt_size(cmt_size)
    );

    typedef struct {
        logic [4:0] v;
        logic [4:0] wb;
        logic       st;
        int         g;
        logic [4:0] er;
        logic [2:0] es;
    } vec_t;

    typedef struct {
        logic         valid;
        logic [1:0]   wid;
        logic [31:0]  pc;
        logic [3:0]   tm;
        logic [5:0]   rd;
        logic [127:0] data;
        logic [2:0]   size;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[18];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic refresh(input int i);
        seq[i]++;
        s_pc[i]   = 32'(32'h1000 * (i + 1) + seq[i] * 4);
        s_wid[i]  = 2'((i + seq[i]) % 4);
        s_rd[i]   = 6'(i * 8 + seq[i] % 8);
        s_tm[i]   = 4'((i + seq[i]) % 15 + 1);
        s_data[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Inputs are already driven; g is the expected grant (-1 for none).
    task automatic cycle(input string nm, input int g, input logic [4:0] er, input logic [2:0] es);
        exp_t e;
        logic [4:0] hs;
        #1;
        chk({nm, " ready"}, 128'(rdy & s_v), 128'(er & s_v));
        if (st_v) chk({nm, " st_ready"}, 128'(st_rdy), 128'(1));
        hs = s_v & ~s_wb;
        e = '{valid: (g >= 0), wid: '0, pc: '0, tm: '0, rd: '0, data: '0, size: es};
        if (g >= 0) begin
            e.wid = s_wid[g]; e.pc = s_pc[g]; e.tm = s_tm[g]; e.rd = s_rd[g]; e.data = s_data[g];
            hs[g] = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, " wb_valid"}, 128'(wb_valid), 128'(e.valid));
        if (e.valid) begin
            chk({nm, " wb_wid"}, 128'(wb_wid), 128'(e.wid));
            chk({nm, " wb_PC"}, 128'(wb_PC), 128'(e.pc));
            chk({nm, " wb_tmask"}, 128'(wb_tmask), 128'(e.tm));
            chk({nm, " wb_rd"}, 128'(wb_rd), 128'(e.rd));
            chk({nm, " wb_data"}, wb_data, e.data);
        end
        chk({nm, " cmt_valid"}, 128'(cmt_valid), 128'(e.size != 0));
        chk({nm, " cmt_size"}, 128'(cmt_size), 128'(e.size));
        for (int i = 0; i < 5; i++) if (hs[i]) refresh(i);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{5'b11111, 5'b11111, 1'b0,  0, 5'b00001, 3'd1};
        tbl[1]  = '{5'b11111, 5'b11111, 1'b0,  1, 5'b00010, 3'd1};
        tbl[2]  = '{5'b11111, 5'b11111, 1'b0,  2, 5'b00100, 3'd1};
        tbl[3]  = '{5'b11111, 5'b11111, 1'b0,  3, 5'b01000, 3'd1};
        tbl[4]  = '{5'b11111, 5'b11111, 1'b0,  4, 5'b10000, 3'd1};
        tbl[5]  = '{5'b10110, 5'b00110, 1'b1,  1, 5'b11011, 3'd3};
        tbl[6]  = '{5'b00100, 5'b00100, 1'b0,  2, 5'b00100, 3'd1};
        tbl[7]  = '{5'b01000, 5'b01000, 1'b0,  3, 5'b01000, 3'd1};
        tbl[8]  = '{5'b01111, 5'b01111, 1'b0,  0, 5'b00001, 3'd1};
        tbl[9]  = '{5'b01111, 5'b01111, 1'b0,  1, 5'b00010, 3'd1};
        tbl[10] = '{5'b01111, 5'b01111, 1'b0,  2, 5'b00100, 3'd1};
        tbl[11] = '{5'b01111, 5'b01111, 1'b0,  3, 5'b01000, 3'd1};
        tbl[12] = '{5'b00000, 5'b00000, 1'b0, -1, 5'b00000, 3'd0};
        tbl[13] = '{5'b11111, 5'b00000, 1'b1, -1, 5'b11111, 3'd6};
        tbl[14] = '{5'b11111, 5'b00001, 1'b1,  0, 5'b11111, 3'd6};
        tbl[15] = '{5'b10000, 5'b10000, 1'b0,  4, 5'b10000, 3'd1};
        tbl[16] = '{5'b00011, 5'b00011, 1'b0,  0, 5'b00001, 3'd1};
        tbl[17] = '{5'b00011, 5'b00011, 1'b0,  1, 5'b00010, 3'd1};

        for (int i = 0; i < 5; i++) begin
            seq[i] = 0;
            refresh(i);
        end
        reset = 1'b0;
        s_v   = 5'b11111;
        s_wb  = 5'b11111;
        st_v  = 1'b1;
        #1;
        chk("reset ready", 128'(rdy), 128'(0));
        chk("reset st_ready", 128'(st_rdy), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset wb_valid", 128'(wb_valid), 128'(0));
        chk("reset cmt_size", 128'(cmt_size), 128'(0));
        reset = 1'b1;

        for (int j = 0; j < 18; j++) begin
            s_v  = tbl[j].v;
            s_wb = tbl[j].wb;
            st_v = tbl[j].st;
            cycle($sformatf("vec%0d", j), tbl[j].g, tbl[j].er, tbl[j].es);
        end

        s_v = 5'b00001; s_wb = 5'b00001; st_v = 1'b0;
        s_wid[0] = 2'd2; s_rd[0] = 6'd5; s_tm[0] = 4'b1011; s_data[0] = {4{32'hDEADBEEF}};
        cycle("single", 0, 5'b00001, 3'd1);

        s_v = 5'b00010; s_wb = 5'b00010;
        #1;
        chk("midrst ld ready", 128'(rdy[1]), 128'(1));
        @(posedge clk);
        #1;
        chk("midrst pre wb_valid", 128'(wb_valid), 128'(1));
        reset = 1'b0;
        #1;
        chk("midrst wb_valid", 128'(wb_valid), 128'(0));
        chk("midrst cmt_size", 128'(cmt_size), 128'(0));
        chk("midrst ready", 128'(rdy), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        s_v = 5'b00011; s_wb = 5'b00011;
        cycle("rst alu first", 0, 5'b00001, 3'd1);
        cycle("rst ld again", 1, 5'b00010, 3'd1);
        s_v = 5'b00000; s_wb = 5'b00000;
        cycle("rst idle", -1, 5'b00000, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
